udp2rgb: RTL and testbench

- Receive-side depacketizer, the counterpart of the rgb2udp packer.
- Takes the byte-wide UDP payload stream from the Ethernet UDP receive path. Each packet carries one video line: a 4-byte header followed by LINE_PIX RGB pixels.
- Emits 24-bit pix_t pixels with line/frame markers toward a pixel sink (e.g. the HDMI async-FIFO path).
- Validates packet length and line sequence, and keeps saturating packet/error counters for debug.

---
 rtl/udp2rgb_pkg.sv | 13 +
 rtl/udp2rgb_cnt.sv | 20 ++
 rtl/udp2rgb.sv | 131 +++++++++++++
 tb/tb_udp2rgb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/udp2rgb_pkg.sv
// Shared types and constants for the UDP-to-pixel depacketizer.
package udp2rgb_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  localparam int UDP_HDR_BYTES = 4;
  localparam int SOF_BIT       = 0;

  typedef enum logic [1:0] {HDR, PIX, DRAIN} state_t;
endpackage

// File: rtl/udp2rgb_cnt.sv
// Saturating up-counter with a multi-bit increment per cycle.
module udp2rgb_cnt #(
  parameter int W     = 16,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     cnt
);
  logic [W:0] sum;

  assign sum = {1'b0, cnt} + (W+1)'(inc);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)   cnt <= '0;
    else if (sum[W]) cnt <= '1;
    else             cnt <= sum[W-1:0];
  end
endmodule

// File: rtl/udp2rgb.sv
// Byte-stream depacketizer: 4-byte line header + LINE_PIX RGB pixels per UDP
// payload, with length/sequence checking and saturating debug counters.
module udp2rgb
  import udp2rgb_pkg::*;
#(
  parameter int LINE_PIX = 1920,
  parameter int LINE_W   = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_last,
  output logic              rx_ready,
  output pix_t              pix,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [LINE_W-1:0] line_num,
  output logic              err_short,
  output logic              err_long,
  output logic              err_seq,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int PIX_W = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;

  state_t             state;
  logic               alive;
  logic [1:0]         hdr_idx;
  logic [1:0]         byte_idx;
  logic [PIX_W-1:0]   pix_idx;
  logic               sof_flag, hdr_sof;
  logic [7:0]         line_hi, r_q, g_q;
  logic [LINE_W-1:0]  prev_line, hdr_line;
  logic               prev_valid, pkt_good;
  logic               acc, last_pix, seq_bad;
  logic [1:0]         err_inc;

  // rx_ready stays low through reset and only throttles the byte that would
  // overwrite a pixel the sink has not yet taken.
  assign rx_ready = alive && !(state == PIX && byte_idx == 2'd2 && pix_valid && !pix_ready);
  assign acc      = rx_valid && rx_ready;
  assign last_pix = (pix_idx == PIX_W'(LINE_PIX-1));
  assign hdr_line = LINE_W'({line_hi, rx_data});
  assign seq_bad  = !sof_flag && prev_valid && (hdr_line != LINE_W'(prev_line + 1'b1));
  assign err_inc  = {1'b0, err_short} + {1'b0, err_long} + {1'b0, err_seq};

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= HDR;      alive <= 1'b0;
      hdr_idx <= '0;     byte_idx <= '0;   pix_idx <= '0;
      sof_flag <= 1'b0;  hdr_sof <= 1'b0;
      line_hi <= '0;     r_q <= '0;        g_q <= '0;
      prev_line <= '0;   prev_valid <= 1'b0;
      pix <= '0;         pix_valid <= 1'b0;
      pix_sof <= 1'b0;   pix_eol <= 1'b0;  line_num <= '0;
      err_short <= 1'b0; err_long <= 1'b0; err_seq <= 1'b0;
      pkt_good <= 1'b0;
    end else begin
      alive     <= 1'b1;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_seq   <= 1'b0;
      pkt_good  <= 1'b0;
      if (pix_valid && pix_ready) pix_valid <= 1'b0;
      if (acc) begin
        case (state)
          HDR: begin
            if (hdr_idx == 2'd0) sof_flag <= rx_data[SOF_BIT];
            if (hdr_idx == 2'd2) line_hi  <= rx_data;
            if (rx_last) begin
              err_short <= 1'b1;
              hdr_idx   <= '0;
            end else if (hdr_idx == 2'(UDP_HDR_BYTES-1)) begin
              hdr_idx    <= '0;
              line_num   <= hdr_line;
              hdr_sof    <= sof_flag;
              err_seq    <= seq_bad;
              prev_line  <= hdr_line;
              prev_valid <= 1'b1;
              byte_idx   <= '0;
              pix_idx    <= '0;
              state      <= PIX;
            end else begin
              hdr_idx <= hdr_idx + 2'd1;
            end
          end
          PIX: begin
            if (byte_idx == 2'd0) r_q <= rx_data;
            if (byte_idx == 2'd1) g_q <= rx_data;
            if (byte_idx == 2'd2) begin
              pix       <= {r_q, g_q, rx_data};
              pix_valid <= 1'b1;
              pix_sof   <= hdr_sof && (pix_idx == '0);
              pix_eol   <= last_pix;
              byte_idx  <= '0;
              pix_idx   <= pix_idx + 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
            if (byte_idx == 2'd2 && last_pix) begin
              if (rx_last) begin
                pkt_good <= 1'b1;
                state    <= HDR;
              end else begin
                err_long <= 1'b1;
                state    <= DRAIN;
              end
            end else if (rx_last) begin
              err_short <= 1'b1;
              state     <= HDR;
            end
          end
          DRAIN: if (rx_last) state <= HDR;
          default: state <= HDR;
        endcase
      end
    end
  end

  udp2rgb_cnt #(.W(CNT_W), .INC_W(1)) u_pkt_cnt (
    .clk(clk), .areset_n(areset_n), .inc(pkt_good), .cnt(pkt_cnt)
  );

  udp2rgb_cnt #(.W(CNT_W), .INC_W(2)) u_err_cnt (
    .clk(clk), .areset_n(areset_n), .inc(err_inc), .cnt(err_cnt)
  );
endmodule

// File: tb/tb_udp2rgb.sv
// Directed bench for udp2rgb with LINE_PIX=4: framing, sequence, length errors,
// sink backpressure and asynchronous reset.
module tb_udp2rgb;
  import udp2rgb_pkg::*;
  localparam int LP = 4;

  logic        clk = 1'b0, areset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_last = 1'b0, rx_ready;
  pix_t        pix;
  logic        pix_valid, pix_ready, pix_sof, pix_eol;
  logic [15:0] line_num, pkt_cnt, err_cnt;
  logic        err_short, err_long, err_seq;

  int n_chk = 0, n_fail = 0, n_stall = 0;
  int n_short = 0, n_long = 0, n_seq = 0;
  int s, es, el, eq;
  bit bp_en = 1'b0;
  int bp_div = 3;
  int phase = 0;
  logic [25:0] pq[$];

  udp2rgb #(.LINE_PIX(LP), .LINE_W(16), .CNT_W(16)) dut (
    .clk(clk), .areset_n(areset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_last(rx_last), .rx_ready(rx_ready), .pix(pix), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .line_num(line_num), .err_short(err_short), .err_long(err_long),
    .err_seq(err_seq), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Sink: ready one cycle in bp_div while backpressure is enabled.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        phase     = (phase >= bp_div-1) ? 0 : phase + 1;
        pix_ready = (phase == 0);
      end else begin
        pix_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (pix_valid && pix_ready) pq.push_back({pix, pix_sof, pix_eol});
    if (err_short) n_short++;
    if (err_long)  n_long++;
    if (err_seq)   n_seq++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit l, input bit is_b);
    int n;
    bit acc;
    rx_valid = 1'b1; rx_data = d; rx_last = l; n = 0;
    do begin
      @(negedge clk);
      acc = rx_ready;
      if (bp_en) chk("rdy_b_only", rx_ready, !(is_b && pix_valid && !pix_ready));
      if (!acc) n_stall++;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  task automatic send_hdr(input bit sof, input logic [15:0] line, input bit last);
    send_byte({7'd0, sof}, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(line[15:8], 1'b0, 1'b0);
    send_byte(line[7:0], last, 1'b0);
  endtask

  task automatic send_pkt(input bit sof, input logic [15:0] line, input logic [7:0] base, input int nb);
    send_hdr(sof, line, nb == 0);
    for (int i = 0; i < nb; i++)
      send_byte(8'(int'(base) + i), i == nb-1, (i < 3*LP) && (i % 3 == 2));
  endtask

  task automatic chk_pix(input int start, input logic [7:0] base, input int n, input bit sof, input bit eol);
    logic [25:0] e;
    chk("pix_count", pq.size() - start, n);
    for (int k = 0; k < n; k++) begin
      if (start + k < pq.size()) begin
        e = {8'(int'(base) + 3*k), 8'(int'(base) + 3*k + 1), 8'(int'(base) + 3*k + 2),
             sof && (k == 0), eol && (k == LP-1)};
        chk($sformatf("pix%0d", k), pq[start+k], e);
      end
    end
  endtask

  task automatic snap;
    s = pq.size(); es = n_short; el = n_long; eq = n_seq;
  endtask

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_line", line_num, 0);
    areset_n = 1'b1;
    wait_cycles(2);

    // Good SOF line 5: literal expectations.
    snap();
    send_pkt(1'b1, 16'd5, 8'h10, 12);
    wait_cycles(6);
    chk("g_count", pq.size() - s, 4);
    if (pq.size() >= s + 4) begin
      chk("g_p0", pq[s],   {24'h101112, 2'b10});
      chk("g_p1", pq[s+1], {24'h131415, 2'b00});
      chk("g_p2", pq[s+2], {24'h161718, 2'b00});
      chk("g_p3", pq[s+3], {24'h191A1B, 2'b01});
    end
    chk("g_line", line_num, 5);
    chk("g_pkt", pkt_cnt, 1);
    chk("g_err", err_cnt, 0);
    chk("g_pulses", (n_short-es) + (n_long-el) + (n_seq-eq), 0);

    // Sequence: 6 follows 5, 8 skips 7.
    snap();
    send_pkt(1'b0, 16'd6, 8'h20, 12);
    wait_cycles(4);
    chk("seq6_none", n_seq - eq, 0);
    chk_pix(s, 8'h20, 4, 1'b0, 1'b1);
    snap();
    send_pkt(1'b0, 16'd8, 8'h40, 12);
    wait_cycles(6);
    chk("seq8_pulse", n_seq - eq, 1);
    chk_pix(s, 8'h40, 4, 1'b0, 1'b1);
    chk("seq8_line", line_num, 8);
    chk("seq_err_cnt", err_cnt, 1);
    chk("seq_pkt", pkt_cnt, 3);

    // Short: 7 payload bytes.
    snap();
    send_pkt(1'b0, 16'd9, 8'h30, 7);
    wait_cycles(6);
    chk_pix(s, 8'h30, 2, 1'b0, 1'b0);
    chk("short_pulse", n_short - es, 1);
    chk("short_err_cnt", err_cnt, 2);
    chk("short_pkt", pkt_cnt, 3);
    snap();
    send_pkt(1'b0, 16'd10, 8'hA0, 12);
    wait_cycles(6);
    chk_pix(s, 8'hA0, 4, 1'b0, 1'b1);
    chk("after_short_seq", n_seq - eq, 0);
    chk("after_short_line", line_num, 10);
    chk("after_short_pkt", pkt_cnt, 4);

    // Long: 15 payload bytes, 3 drained.
    snap();
    send_pkt(1'b0, 16'd11, 8'h50, 15);
    wait_cycles(6);
    chk_pix(s, 8'h50, 4, 1'b0, 1'b1);
    chk("long_pulse", n_long - el, 1);
    chk("long_pkt", pkt_cnt, 4);
    chk("long_err_cnt", err_cnt, 3);
    snap();
    send_pkt(1'b0, 16'd12, 8'hB0, 12);
    wait_cycles(6);
    chk_pix(s, 8'hB0, 4, 1'b0, 1'b1);
    chk("after_long_pkt", pkt_cnt, 5);
    chk("after_long_err", err_cnt, 3);

    // Backpressure: one-in-three, then one-in-four which must stall the B byte.
    bp_div = 3; bp_en = 1'b1;
    snap();
    send_pkt(1'b0, 16'd13, 8'hC0, 12);
    wait_cycles(10);
    chk_pix(s, 8'hC0, 4, 1'b0, 1'b1);
    bp_div = 4; n_stall = 0;
    snap();
    send_pkt(1'b0, 16'd14, 8'hD0, 12);
    wait_cycles(12);
    chk_pix(s, 8'hD0, 4, 1'b0, 1'b1);
    chk("bp_stall_seen", n_stall > 0, 1);
    bp_en = 1'b0;
    wait_cycles(2);
    chk("bp_pkt", pkt_cnt, 7);
    chk("bp_err", err_cnt, 3);

    // Async reset in the middle of the pixel phase.
    send_hdr(1'b1, 16'd15, 1'b0);
    send_byte(8'h70, 1'b0, 1'b0);
    send_byte(8'h71, 1'b0, 1'b0);
    send_byte(8'h72, 1'b0, 1'b1);
    send_byte(8'h73, 1'b0, 1'b0);
    areset_n = 1'b0;
    #1;
    chk("arst_rx_ready", rx_ready, 0);
    chk("arst_pix_valid", pix_valid, 0);
    chk("arst_pix", pix, 0);
    chk("arst_pkt", pkt_cnt, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_line", line_num, 0);
    wait_cycles(1);
    areset_n = 1'b1;
    wait_cycles(1);
    snap();
    send_pkt(1'b1, 16'd3, 8'h80, 12);
    wait_cycles(6);
    chk_pix(s, 8'h80, 4, 1'b1, 1'b1);
    chk("post_rst_line", line_num, 3);
    chk("post_rst_pkt", pkt_cnt, 1);
    chk("post_rst_err", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
